// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream decoder: classifies high-pulse widths into bits, packs
// 24-bit MSB-first words and emits them with their LED index as write strobes.

module ws2812_rx #(
    parameter int NUM_LEDS   = 8,
    parameter int CLK_MHZ    = 12,
    parameter int T_THRESH   = 8,
    parameter int T_MIN_HIGH = 2,
    parameter int T_MAX_HIGH = 24,
    parameter int T_RESET    = CLK_MHZ * 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        write,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        bit_error
);

    localparam int CNT_W = $clog2(T_RESET + 1);
    localparam int LED_W = $clog2(NUM_LEDS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RESET    = CNT_W'(T_RESET);
    localparam logic [CNT_W-1:0] CNT_THRESH   = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] CNT_MIN_HIGH = CNT_W'(T_MIN_HIGH);
    localparam logic [CNT_W-1:0] CNT_MAX_HIGH = CNT_W'(T_MAX_HIGH);
    localparam logic [LED_W-1:0] LED_ZERO     = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] LED_ONE      = LED_W'(1);
    localparam logic [LED_W-1:0] LED_MAX      = LED_W'(NUM_LEDS);
    localparam logic [4:0]       BIT_ZERO     = 5'd0;
    localparam logic [4:0]       BIT_ONE      = 5'd1;
    localparam logic [4:0]       BIT_LAST     = 5'd23;

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_RESET) begin
            sat_inc = CNT_RESET;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic             sync_meta_r;
    logic             din_sync_r;
    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [4:0]       bit_idx_r, bit_idx_nxt_s;
    logic [23:0]      shift_r, shift_nxt_s;
    logic [LED_W-1:0] led_idx_r, led_idx_nxt_s;
    logic [23:0]      rgb_data_r, rgb_data_nxt_s;
    logic [7:0]       led_num_r, led_num_nxt_s;
    logic             write_r, write_nxt_s;
    logic             frame_done_r, frame_done_nxt_s;
    logic [7:0]       frame_count_r, frame_count_nxt_s;
    logic             bit_error_r, bit_error_nxt_s;
    logic             bit_val_s;
    logic [23:0]      new_word_s;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta_r <= 1'b0;
            din_sync_r  <= 1'b0;
        end else begin
            sync_meta_r <= din;
            din_sync_r  <= sync_meta_r;
        end
    end

    // Next-state, datapath and output decode for the pulse-width receiver.
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        bit_idx_nxt_s     = bit_idx_r;
        shift_nxt_s       = shift_r;
        led_idx_nxt_s     = led_idx_r;
        rgb_data_nxt_s    = rgb_data_r;
        led_num_nxt_s     = led_num_r;
        write_nxt_s       = 1'b0;
        frame_done_nxt_s  = 1'b0;
        frame_count_nxt_s = frame_count_r;
        bit_error_nxt_s   = 1'b0;
        bit_val_s         = (cnt_r >= CNT_THRESH);
        new_word_s        = {shift_r[22:0], bit_val_s};

        case (state_r)
            ST_ARM: begin
                if (din_sync_r) begin
                    cnt_nxt_s = CNT_ZERO;
                end else if (cnt_r == CNT_RESET) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_IDLE: begin
                led_idx_nxt_s = LED_ZERO;
                bit_idx_nxt_s = BIT_ZERO;
                shift_nxt_s   = 24'h000000;
                if (din_sync_r) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            ST_HIGH: begin
                // Over-length check wins even on the falling-edge cycle.
                if (cnt_r > CNT_MAX_HIGH) begin
                    bit_error_nxt_s = 1'b1;
                    state_nxt_s     = ST_ERROR;
                    cnt_nxt_s       = CNT_ZERO;
                end else if (din_sync_r) begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end else if (cnt_r < CNT_MIN_HIGH) begin
                    bit_error_nxt_s = 1'b1;
                    state_nxt_s     = ST_ERROR;
                    cnt_nxt_s       = CNT_ZERO;
                end else begin
                    shift_nxt_s = new_word_s;
                    state_nxt_s = ST_LOW;
                    cnt_nxt_s   = CNT_ZERO;
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_nxt_s = BIT_ZERO;
                        if (led_idx_r != LED_MAX) begin
                            write_nxt_s    = 1'b1;
                            rgb_data_nxt_s = new_word_s;
                            led_num_nxt_s  = 8'(led_idx_r);
                            led_idx_nxt_s  = led_idx_r + LED_ONE;
                        end else begin
                            led_idx_nxt_s = led_idx_r;
                        end
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + BIT_ONE;
                    end
                end
            end
            ST_LOW: begin
                if (din_sync_r) begin
                    state_nxt_s = ST_HIGH;
                    cnt_nxt_s   = CNT_ONE;
                end else if (cnt_r == CNT_RESET) begin
                    frame_done_nxt_s  = 1'b1;
                    frame_count_nxt_s = 8'(led_idx_r);
                    bit_error_nxt_s   = (bit_idx_r != BIT_ZERO);
                    state_nxt_s       = ST_IDLE;
                    cnt_nxt_s         = CNT_ZERO;
                end else begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end
            end
            ST_ERROR: begin
                if (!din_sync_r) begin
                    state_nxt_s = ST_ARM;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_ARM;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and registered-output update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_ARM;
            cnt_r         <= CNT_ZERO;
            bit_idx_r     <= BIT_ZERO;
            shift_r       <= 24'h000000;
            led_idx_r     <= LED_ZERO;
            rgb_data_r    <= 24'h000000;
            led_num_r     <= 8'h00;
            write_r       <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 8'h00;
            bit_error_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            bit_idx_r     <= bit_idx_nxt_s;
            shift_r       <= shift_nxt_s;
            led_idx_r     <= led_idx_nxt_s;
            rgb_data_r    <= rgb_data_nxt_s;
            led_num_r     <= led_num_nxt_s;
            write_r       <= write_nxt_s;
            frame_done_r  <= frame_done_nxt_s;
            frame_count_r <= frame_count_nxt_s;
            bit_error_r   <= bit_error_nxt_s;
        end
    end

    assign rgb_data    = rgb_data_r;
    assign led_num     = led_num_r;
    assign write       = write_r;
    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;
    assign bit_error   = bit_error_r;

    ws2812_rx_checker #(.NUM_LEDS(NUM_LEDS)) u_checker (
        .clk         (clk),
        .reset       (reset),
        .write       (write_r),
        .frame_done  (frame_done_r),
        .led_num     (led_num_r),
        .frame_count (frame_count_r)
    );

endmodule

module ws2812_rx_checker #(
    parameter int NUM_LEDS = 8
) (
    input logic       clk,
    input logic       reset,
    input logic       write,
    input logic       frame_done,
    input logic [7:0] led_num,
    input logic [7:0] frame_count
);

    // Strobes are single-cycle, never coincide, and indices stay in range.
    a_write_pulse: assert property (@(posedge clk) disable iff (!reset) write |=> !write);
    a_done_pulse:  assert property (@(posedge clk) disable iff (!reset) frame_done |=> !frame_done);
    a_exclusive:   assert property (@(posedge clk) disable iff (!reset) !(write && frame_done));
    a_led_range:   assert property (@(posedge clk) disable iff (!reset) write |-> (led_num < 8'(NUM_LEDS)));
    a_fc_range:    assert property (@(posedge clk) disable iff (!reset) frame_done |-> (frame_count <= 8'(NUM_LEDS)));

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed self-checking bench for ws2812_rx at default parameters.

module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        write;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        bit_error;

    int n_checks = 0;
    int n_pass   = 0;

    int          wr_total     = 0;
    int          fd_total     = 0;
    int          fd_err_total = 0;
    int          err_total    = 0;
    logic [7:0]  last_fc      = 8'd0;
    logic [31:0] wr_log [0:63];

    int base_wr, base_fd, base_err, base_fde;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .rgb_data    (rgb_data),
        .led_num     (led_num),
        .write       (write),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .bit_error   (bit_error)
    );

    // Strobe monitor sampling on the inactive edge.
    always @(negedge clk) begin
        if (write) begin
            if (wr_total < 64) wr_log[wr_total] <= {led_num, rgb_data};
            wr_total <= wr_total + 1;
        end
        if (frame_done) begin
            fd_total <= fd_total + 1;
            last_fc  <= frame_count;
        end
        if (bit_error) err_total <= err_total + 1;
        if (frame_done && bit_error) fd_err_total <= fd_err_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, 9);
            hold(1'b0, 5);
        end else begin
            hold(1'b1, 4);
            hold(1'b0, 10);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic mark();
        base_wr  = wr_total;
        base_fd  = fd_total;
        base_err = err_total;
        base_fde = fd_err_total;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rgb"},   32'(rgb_data),    32'd0);
        check({tag, "_led"},   32'(led_num),     32'd0);
        check({tag, "_wr"},    32'(write),       32'd0);
        check({tag, "_fd"},    32'(frame_done),  32'd0);
        check({tag, "_fc"},    32'(frame_count), 32'd0);
        check({tag, "_err"},   32'(bit_error),   32'd0);
    endtask

    initial begin
        reset = 1'b0;
        din   = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        reset = 1'b1;
        hold(1'b0, 650);

        // Two-word frame as the driver would send it.
        mark();
        send_word(24'hFF0055);
        send_word(24'h00A5C3);
        hold(1'b0, 650);
        check("lb_writes", 32'(wr_total - base_wr), 32'd2);
        check("lb_w0", wr_log[base_wr], {8'd0, 24'hFF0055});
        check("lb_w1", wr_log[base_wr + 1], {8'd1, 24'h00A5C3});
        check("lb_fd", 32'(fd_total - base_fd), 32'd1);
        check("lb_fc", 32'(last_fc), 32'd2);
        check("lb_err", 32'(err_total - base_err), 32'd0);
        check("lb_hold_rgb", 32'(rgb_data), 32'h00A5C3);
        check("lb_hold_fc", 32'(frame_count), 32'd2);

        // Width threshold: 7 clocks decodes 0, 8 clocks decodes 1.
        mark();
        for (int i = 0; i < 12; i++) begin
            hold(1'b1, 7);
            hold(1'b0, 8);
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        hold(1'b0, 650);
        check("th_writes", 32'(wr_total - base_wr), 32'd1);
        check("th_word", wr_log[base_wr], {8'd0, 24'h555555});
        check("th_fc", 32'(last_fc), 32'd1);
        check("th_err", 32'(err_total - base_err), 32'd0);

        // Overflow: ten words, only the first eight are accepted.
        mark();
        for (int i = 0; i < 10; i++) send_word({8'(i), 16'hC3A5});
        hold(1'b0, 650);
        check("ov_writes", 32'(wr_total - base_wr), 32'd8);
        check("ov_first", wr_log[base_wr], {8'd0, 24'h00C3A5});
        check("ov_last", wr_log[base_wr + 7], {8'd7, 24'h07C3A5});
        check("ov_fc", 32'(last_fc), 32'd8);
        check("ov_err", 32'(err_total - base_err), 32'd0);

        // Glitch then stuck-high, each followed by re-arm.
        mark();
        hold(1'b1, 1);
        hold(1'b0, 20);
        check("gl_err", 32'(err_total - base_err), 32'd1);
        check("gl_writes", 32'(wr_total - base_wr), 32'd0);
        hold(1'b0, 650);
        hold(1'b1, 30);
        hold(1'b0, 650);
        check("st_err", 32'(err_total - base_err), 32'd2);
        check("st_fd", 32'(fd_total - base_fd), 32'd0);
        check("st_writes", 32'(wr_total - base_wr), 32'd0);
        send_word(24'h123456);
        hold(1'b0, 650);
        check("rc_fd", 32'(fd_total - base_fd), 32'd1);
        check("rc_word", wr_log[base_wr], {8'd0, 24'h123456});
        check("rc_err", 32'(err_total - base_err), 32'd2);

        // Partial word at end of frame.
        mark();
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        hold(1'b0, 650);
        check("pw_fd", 32'(fd_total - base_fd), 32'd1);
        check("pw_fc", 32'(last_fc), 32'd0);
        check("pw_fd_err", 32'(fd_err_total - base_fde), 32'd1);
        check("pw_err", 32'(err_total - base_err), 32'd1);
        check("pw_writes", 32'(wr_total - base_wr), 32'd0);

        // Reset after ten bits, then a clean frame after re-arm.
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        din   = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("mr");
        reset = 1'b1;
        mark();
        hold(1'b0, 650);
        send_word(24'hABCDEF);
        hold(1'b0, 650);
        check("mr_writes", 32'(wr_total - base_wr), 32'd1);
        check("mr_word", wr_log[base_wr], {8'd0, 24'hABCDEF});
        check("mr_fd", 32'(fd_total - base_fd), 32'd1);
        check("mr_fc", 32'(last_fc), 32'd1);
        check("mr_err", 32'(err_total - base_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
